// File: rtl/div_ratio_monitor.sv
// Measures the period and high-phase length of a divided clock sampled in the
// reference domain, and reports lock, ratio change, stall and mismatch status.
module div_ratio_monitor #(
    parameter int unsigned LOCK_CNT = 2
) (
    input  logic       i_ref_clk,
    input  logic       i_rst,
    input  logic       i_mon_en,
    input  logic       i_div_clk_smp,
    input  logic [7:0] i_exp_ratio,
    output logic [7:0] o_ratio,
    output logic [7:0] o_high_cnt,
    output logic       o_valid,
    output logic       o_lock,
    output logic       o_err,
    output logic       o_timeout,
    output logic       o_mismatch
);

    typedef enum logic [1:0] {IDLE, SYNC, MEASURE, LOCKED} state_t;

    state_t     state_q;
    logic       prevSmp_q;
    logic [7:0] periodCnt_q;
    logic [7:0] highCnt_q;
    logic [4:0] matchCnt_q;
    logic [7:0] ratio_q;
    logic [7:0] highOut_q;
    logic       valid_q;
    logic       lock_q;
    logic       err_q;
    logic       timeout_q;
    logic       mismatch_q;

    logic       rise_d;
    logic [7:0] period_d;
    logic       periodSame_d;
    logic [4:0] matchCnt_d;
    logic       lockHit_d;

    // Lock is judged on the run length before this capture, so the first
    // capture after SYNC never counts as a repeat of a stale o_ratio.
    always_comb begin
        rise_d       = i_div_clk_smp & ~prevSmp_q;
        period_d     = periodCnt_q + 8'd1;
        periodSame_d = (period_d == ratio_q);
        matchCnt_d   = 5'd1;
        if (periodSame_d) begin
            matchCnt_d = (matchCnt_q == 5'h1F) ? matchCnt_q : matchCnt_q + 5'd1;
        end
        lockHit_d    = periodSame_d && (matchCnt_q >= 5'(LOCK_CNT));
    end

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            prevSmp_q   <= 1'b0;
            periodCnt_q <= 8'd0;
            highCnt_q   <= 8'd0;
            matchCnt_q  <= 5'd0;
            ratio_q     <= 8'd0;
            highOut_q   <= 8'd0;
            valid_q     <= 1'b0;
            lock_q      <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            prevSmp_q  <= i_div_clk_smp;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
            mismatch_q <= lock_q && (ratio_q != i_exp_ratio);
            if (!i_mon_en) begin
                state_q     <= IDLE;
                lock_q      <= 1'b0;
                mismatch_q  <= 1'b0;
                periodCnt_q <= 8'd0;
                highCnt_q   <= 8'd0;
                matchCnt_q  <= 5'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= SYNC;
                    end
                    SYNC: begin
                        if (rise_d) begin
                            periodCnt_q <= 8'd0;
                            highCnt_q   <= {7'd0, i_div_clk_smp};
                            state_q     <= MEASURE;
                        end
                    end
                    MEASURE, LOCKED: begin
                        if (rise_d) begin
                            ratio_q     <= period_d;
                            highOut_q   <= highCnt_q;
                            valid_q     <= 1'b1;
                            periodCnt_q <= 8'd0;
                            highCnt_q   <= 8'd1;
                            matchCnt_q  <= matchCnt_d;
                            if (state_q == MEASURE) begin
                                if (lockHit_d) begin
                                    state_q <= LOCKED;
                                    lock_q  <= 1'b1;
                                end
                            end else if (!periodSame_d) begin
                                err_q   <= 1'b1;
                                lock_q  <= 1'b0;
                                state_q <= MEASURE;
                            end
                        end else if (periodCnt_q == 8'hFF) begin
                            // Stalled input: give up on this period and resynchronise.
                            timeout_q   <= 1'b1;
                            lock_q      <= 1'b0;
                            matchCnt_q  <= 5'd0;
                            periodCnt_q <= 8'd0;
                            highCnt_q   <= 8'd0;
                            state_q     <= SYNC;
                        end else begin
                            periodCnt_q <= periodCnt_q + 8'd1;
                            highCnt_q   <= highCnt_q + {7'd0, i_div_clk_smp};
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_ratio    = ratio_q;
    assign o_high_cnt = highOut_q;
    assign o_valid    = valid_q;
    assign o_lock     = lock_q;
    assign o_err      = err_q;
    assign o_timeout  = timeout_q;
    assign o_mismatch = mismatch_q;

endmodule
